gouram_trace_arbiter: RTL and testbench

Round-robin arbiter that shares one trace sink between several Gouram trace producers, e.g. one per core or one per trace channel. Each producer pushes records without back-pressure, because the core must never stall for tracing. Records are buffered in a small per-source FIFO, and records that arrive when a FIFO is full are dropped. The block sits between the `gouram` trace outputs and the trace sink (DMA/UART/debug port), which does apply a valid/ready back-pressure handshake.

---
 rtl/gouram_trace_pkg.sv | 17 +
 rtl/gouram_trace_fifo.sv | 54 +++++
 rtl/gouram_trace_arbiter.sv | 112 +++++++++++
 tb/tb_gouram_trace_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gouram_trace_pkg.sv
// Shared types and defaults for the Gouram trace arbiter slice.
package gouram_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_format;

  typedef enum logic {
    IDLE,
    VALID
  } arb_state_e;

  localparam int DEFAULT_REC_W      = $bits(trace_format);
  localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/gouram_trace_fifo.sv
// Single-clock per-source trace FIFO; pushes into a full FIFO are ignored.
module gouram_trace_fifo
  import gouram_trace_pkg::*;
#(
  parameter int WIDTH = DEFAULT_REC_W,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign wr_en = push && !full;
  assign rd_en = pop && (count_q != '0);
  assign count = count_q;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gouram_trace_arbiter.sv
// Round-robin arbiter sharing one back-pressured trace sink among NUM_SRC producers.
// Optional per-source drop counters are built when GOURAM_TRACE_DROP_CNT_EN is defined.
module gouram_trace_arbiter
  import gouram_trace_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int REC_W      = DEFAULT_REC_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*REC_W-1:0]     src_data,
  output logic                         sink_valid,
  output logic [REC_W-1:0]             sink_data,
  output logic [$clog2(NUM_SRC)-1:0]   sink_src,
  input  logic                         sink_ready,
  output logic [NUM_SRC-1:0]           fifo_full,
  output logic [NUM_SRC*CNT_W-1:0]     drop_cnt
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_B = $clog2(FIFO_DEPTH) + 1;

  logic [REC_W-1:0] head     [NUM_SRC];
  logic [CNT_B-1:0] count    [NUM_SRC];
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] pop;

  arb_state_e       state;
  logic [SRC_W-1:0] last_grant;
  logic [SRC_W-1:0] win;
  logic             any_ne;
  logic             load;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    gouram_trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (src_valid[i]),
      .pop   (pop[i]),
      .wdata (src_data[i*REC_W +: REC_W]),
      .head  (head[i]),
      .count (count[i]),
      .full  (fifo_full[i])
    );
    assign nonempty[i] = (count[i] != '0);
  end

  // Search starts just after the previous winner; counts are pre-push so
  // a record always spends at least one cycle in its FIFO.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    win    = '0;
    any_ne = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant) + k) % NUM_SRC;
      if (!any_ne && nonempty[idx]) begin
        any_ne = 1'b1;
        win    = idx[SRC_W-1:0];
      end
    end
  end

  assign load = any_ne && ((state == IDLE) || sink_ready);

  always_comb begin
    pop = '0;
    if (load) pop[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sink_data  <= '0;
      sink_src   <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);
    end else if (load) begin
      sink_data  <= head[win];
      sink_src   <= win;
      last_grant <= win;
      state      <= VALID;
    end else if ((state == VALID) && sink_ready) begin
      state <= IDLE;
    end
  end

  assign sink_valid = (state == VALID);

`ifdef GOURAM_TRACE_DROP_CNT_EN
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_drop
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (src_valid[i] && fifo_full[i] && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
    assign drop_cnt[i*CNT_W +: CNT_W] = cnt;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_gouram_trace_arbiter.sv
// Directed scoreboard bench for gouram_trace_arbiter (NUM_SRC=2, FIFO_DEPTH=4).
module tb_gouram_trace_arbiter;

  localparam int NUM_SRC    = 2;
  localparam int REC_W      = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
`ifdef GOURAM_TRACE_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*REC_W-1:0] src_data;
  logic                     sink_valid;
  logic [REC_W-1:0]         sink_data;
  logic [0:0]               sink_src;
  logic                     sink_ready;
  logic [NUM_SRC-1:0]       fifo_full;
  logic [NUM_SRC*CNT_W-1:0] drop_cnt;

  gouram_trace_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .REC_W      (REC_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .sink_valid (sink_valid),
    .sink_data  (sink_data),
    .sink_src   (sink_src),
    .sink_ready (sink_ready),
    .fifo_full  (fifo_full),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  bit          fair_mode = 1'b0;
  bit          have_prev = 1'b0;
  logic        prev_src  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive both sources; records marked in keep are expected to reach the sink.
  task automatic drive(input logic [1:0] v, input logic [1:0] keep,
                       input logic [63:0] d0, input logic [63:0] d1);
    src_valid = v;
    src_data  = {d1, d0};
    if (keep[0]) q0.push_back(d0);
    if (keep[1]) q1.push_back(d1);
  endtask

  // Score any handshake pending on the coming edge, then advance past it.
  task automatic tick();
    logic [63:0] exp;
    logic        exp_src;
    bit          have;
    have = 1'b0;
    exp  = '0;
    if (sink_valid && sink_ready) begin
      if (sink_src == 1'b0 && q0.size() != 0) begin
        exp = q0.pop_front(); have = 1'b1;
      end else if (sink_src == 1'b1 && q1.size() != 0) begin
        exp = q1.pop_front(); have = 1'b1;
      end
      check("sb_expected", 64'(have), 64'd1);
      if (have) check("sb_data", sink_data, exp);
      if (fair_mode && have_prev) begin
        exp_src = ~prev_src;
        check("fair_alternate", 64'(sink_src), 64'(exp_src));
      end
      prev_src  = sink_src;
      have_prev = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q0.size() != 0 || q1.size() != 0); i++) tick();
    check("drain_empty", 64'(q0.size() + q1.size()), 64'd0);
    check("drain_idle", 64'(sink_valid), 64'd0);
  endtask

  initial begin
    rst        = 1'b0;
    src_valid  = '0;
    src_data   = '0;
    sink_ready = 1'b0;
    #3;
    check("rst_valid", 64'(sink_valid), 64'd0);
    check("rst_data", sink_data, 64'd0);
    check("rst_src", 64'(sink_src), 64'd0);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single record: visible after edge N+1 for exactly one cycle.
    sink_ready = 1'b1;
    drive(2'b01, 2'b01, 64'hA5, 64'h0);
    tick();
    drive(2'b00, 2'b00, 64'h0, 64'h0);
    check("single_not_yet", 64'(sink_valid), 64'd0);
    tick();
    check("single_valid", 64'(sink_valid), 64'd1);
    check("single_data", sink_data, 64'hA5);
    check("single_src", 64'(sink_src), 64'd0);
    tick();
    check("single_one_cycle", 64'(sink_valid), 64'd0);

    // Fairness: both sources push together, grants must alternate.
    fair_mode = 1'b1;
    have_prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 2'b11, 64'h1000 + 64'(k), 64'h2000 + 64'(k));
      tick();
    end
    drive(2'b00, 2'b00, 64'h0, 64'h0);
    drain(30);
    fair_mode = 1'b0;

    // Back-pressure: output held stable while sink_ready is low.
    sink_ready = 1'b0;
    drive(2'b01, 2'b01, 64'h1111, 64'h0);
    tick();
    drive(2'b00, 2'b00, 64'h0, 64'h0);
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid", 64'(sink_valid), 64'd1);
      check("bp_data", sink_data, 64'h1111);
      check("bp_src", 64'(sink_src), 64'd0);
    end
    sink_ready = 1'b1;
    tick();
    check("bp_release", 64'(sink_valid), 64'd0);

    // Overflow: 7 pushes into source 1 with the sink stalled; last two drop.
    sink_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(2'b10, (k < 5) ? 2'b10 : 2'b00, 64'h0, 64'h100 + 64'(k));
      tick();
      if (k == 3) check("ovf_not_full_4", 64'(fifo_full[1]), 64'd0);
      if (k == 4) check("ovf_full_5", 64'(fifo_full[1]), 64'd1);
    end
    drive(2'b00, 2'b00, 64'h0, 64'h0);
    check("ovf_drop1", 64'(drop_cnt[31:16]), 64'(DROP_EN * 2));
    check("ovf_drop0", 64'(drop_cnt[15:0]), 64'd0);
    sink_ready = 1'b1;
    drain(30);
    check("ovf_full_cleared", 64'(fifo_full), 64'd0);

    // Push on the same edge a full FIFO 0 is popped: the push is dropped.
    sink_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, 2'b01, 64'h200 + 64'(k), 64'h0);
      tick();
    end
    drive(2'b00, 2'b00, 64'h0, 64'h0);
    check("pp_full", 64'(fifo_full[0]), 64'd1);
    sink_ready = 1'b1;
    drive(2'b01, 2'b00, 64'h2FF, 64'h0);
    tick();
    drive(2'b00, 2'b00, 64'h0, 64'h0);
    check("pp_not_full", 64'(fifo_full[0]), 64'd0);
    check("pp_drop0", 64'(drop_cnt[15:0]), 64'(DROP_EN));
    check("pp_remaining", 64'(q0.size()), 64'(FIFO_DEPTH));
    drain(30);

    // Asynchronous reset mid-stream with source 1 full and the sink stalled.
    sink_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(2'b10, 2'b00, 64'h0, 64'h300 + 64'(k));
      tick();
    end
    drive(2'b00, 2'b00, 64'h0, 64'h0);
    check("pre_rst_valid", 64'(sink_valid), 64'd1);
    check("pre_rst_full", 64'(fifo_full[1]), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(sink_valid), 64'd0);
    check("async_rst_full", 64'(fifo_full), 64'd0);
    check("async_rst_drop", 64'(drop_cnt), 64'd0);
    check("async_rst_data", sink_data, 64'd0);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sink_ready = 1'b1;
    drive(2'b11, 2'b11, 64'h400, 64'h401);
    tick();
    drive(2'b00, 2'b00, 64'h0, 64'h0);
    tick();
    check("post_rst_valid", 64'(sink_valid), 64'd1);
    check("post_rst_src", 64'(sink_src), 64'd0);
    check("post_rst_data", sink_data, 64'h400);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
